// File: rtl/core_pkg.sv
// Shared core-controller encodings: FSM states, inst word bit positions, idle word.
// Pure definitions, no logic; imported by core_ctrl and core_ctrl_ldr.
package core_pkg;

    localparam int INST_W = 34;
    localparam int ADDR_F = 11;

    localparam int B_ACC      = 33;
    localparam int B_PMEM_CEN = 32;
    localparam int B_PMEM_WEN = 31;
    localparam int B_PMEM_A   = 20;
    localparam int B_XMEM_CEN = 19;
    localparam int B_XMEM_WEN = 18;
    localparam int B_XMEM_A   = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXECUTE  = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs deselected (CEN=1, WEN=1), addresses 0, every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WLD_L0  = 3'd1;
    localparam logic [2:0] S_WLD_ARR = 3'd2;
    localparam logic [2:0] S_ACT_L0  = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_ctrl_ldr.sv
// Streams count_i words from base_i into L0: xmem read, then l0_wr one cycle later.
// At most one read per 2 cycles; l0_full_i freezes the address counter.
module core_ctrl_ldr
    import core_pkg::*;
#(
    parameter int addr_w = 11,
    parameter int CW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [addr_w-1:0] base_i,
    input  logic [CW-1:0]     count_i,
    input  logic              l0_full_i,
    output logic              rd_o,
    output logic [addr_w-1:0] addr_o,
    output logic              wr_o,
    output logic              last_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;

    always_comb begin
        // A pending write blocks the next read, which caps throughput at one word per 2 cycles.
        rd_o   = en_i && !l0_full_i && !pend_q && (cnt_q < count_i);
        pend_d = rd_o;
        cnt_d  = en_i ? (cnt_q + CW'(rd_o)) : '0;
        addr_o = base_i + addr_w'(cnt_q);
        wr_o   = pend_q;
        last_o = en_i && pend_q && (cnt_q == count_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Tile sequencer for the PE core: weight load, array load/flush, activation load, execute, psum drain.
// inst is fully registered; start accepted only in IDLE. CORE_CTRL_PERF_EN adds the cyc_cnt busy-cycle counter.
module core_ctrl
    import core_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int len_w  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] x_base,
    input  logic [addr_w-1:0] p_base,
    input  logic [len_w-1:0]  len,
    input  logic              l0_full,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [15:0]       cyc_cnt
`endif
);

    localparam int CW = max2(len_w, $clog2(row + 1));
    localparam int PW = max2(CW, $clog2(row + col + 1));
    localparam logic [PW-1:0] LOAD_N     = PW'(row);
    localparam logic [PW-1:0] FLUSH_LAST = PW'(row + col - 1);

    logic [2:0]        st_q, st_d;
    logic [PW-1:0]     ph_q, ph_d, ph_nx;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, done_q;
    logic [addr_w-1:0] w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
    logic [len_w-1:0]  len_q, len_d;

    logic              ldr_en, ldr_rd, ldr_wr, ldr_last;
    logic [addr_w-1:0] ldr_base, ldr_addr, p_addr;
    logic [CW-1:0]     ldr_cnt;

    assign ldr_en   = (st_q == S_WLD_L0) || (st_q == S_ACT_L0);
    assign ldr_base = (st_q == S_ACT_L0) ? x_base_q : w_base_q;
    assign ldr_cnt  = (st_q == S_ACT_L0) ? CW'(len_q) : CW'(row);
    assign ph_nx    = ph_q + PW'(1);
    assign p_addr   = p_base_q + addr_w'(ph_q);

    core_ctrl_ldr #(
        .addr_w (addr_w),
        .CW     (CW)
    ) u_ldr (
        .clk       (clk),
        .reset     (reset),
        .en_i      (ldr_en),
        .base_i    (ldr_base),
        .count_i   (ldr_cnt),
        .l0_full_i (l0_full),
        .rd_o      (ldr_rd),
        .addr_o    (ldr_addr),
        .wr_o      (ldr_wr),
        .last_o    (ldr_last)
    );

    always_comb begin
        st_d     = st_q;
        ph_d     = ph_q;
        inst_d   = INST_IDLE;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        p_base_d = p_base_q;
        len_d    = len_q;

        if (ldr_rd) begin
            inst_d[B_XMEM_CEN]           = 1'b0;
            inst_d[B_XMEM_A +: ADDR_F]   = ADDR_F'(ldr_addr);
        end
        if (ldr_en && ldr_wr) begin
            inst_d[B_L0_WR] = 1'b1;
        end

        case (st_q)
            S_IDLE: begin
                if (start) begin
                    w_base_d = w_base;
                    x_base_d = x_base;
                    p_base_d = p_base;
                    len_d    = (len == '0) ? len_w'(1) : len;
                    ph_d     = '0;
                    st_d     = S_WLD_L0;
                end
            end
            S_WLD_L0: begin
                if (ldr_last) begin
                    ph_d = '0;
                    st_d = S_WLD_ARR;
                end
            end
            S_WLD_ARR: begin
                // row cycles of weight shift-in, then col quiet cycles to flush the array.
                if (ph_q < LOAD_N) begin
                    inst_d[B_L0_RD] = 1'b1;
                    inst_d[B_LOAD]  = 1'b1;
                end
                ph_d = ph_nx;
                if (ph_q == FLUSH_LAST) begin
                    ph_d = '0;
                    st_d = S_ACT_L0;
                end
            end
            S_ACT_L0: begin
                if (ldr_last) begin
                    ph_d = '0;
                    st_d = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_d[B_L0_RD]   = 1'b1;
                inst_d[B_EXECUTE] = 1'b1;
                ph_d = ph_nx;
                if (ph_nx == PW'(len_q)) begin
                    ph_d = '0;
                    st_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    inst_d[B_OFIFO_RD]         = 1'b1;
                    inst_d[B_PMEM_CEN]         = 1'b0;
                    inst_d[B_PMEM_WEN]         = 1'b0;
                    inst_d[B_PMEM_A +: ADDR_F] = ADDR_F'(p_addr);
                    ph_d = ph_nx;
                    if (ph_nx == PW'(len_q)) begin
                        st_d = S_DONE;
                    end
                end
            end
            S_DONE:  st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= S_IDLE;
            ph_q     <= '0;
            inst_q   <= INST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            len_q    <= '0;
        end else begin
            st_q     <= st_d;
            ph_q     <= ph_d;
            inst_q   <= inst_d;
            busy_q   <= (st_d != S_IDLE);
            done_q   <= (st_d == S_DONE);
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            p_base_q <= p_base_d;
            len_q    <= len_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef CORE_CTRL_PERF_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (st_q == S_IDLE) begin
            if (start) begin
                cyc_d = '0;
            end
        end else if (cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized tile bench for core_ctrl: per-tile event scoreboard against the expected tile transaction.
module tb_core_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, l0_full, ofifo_valid;
    logic [10:0] w_base, x_base, p_base;
    logic [6:0]  len;
    logic [33:0] inst;
    logic        busy, done;
`ifdef CORE_CTRL_PERF_EN
    logic [15:0] cyc_cnt;
`endif

    core_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .w_base      (w_base),
        .x_base      (x_base),
        .p_base      (p_base),
        .len         (len),
        .l0_full     (l0_full),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
`ifdef CORE_CTRL_PERF_EN
        ,
        .cyc_cnt     (cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observed events of the current tile, tagged with the sample cycle.
    int rd_addr[$], rd_cyc[$], wr_cyc[$], load_cyc[$], exec_cyc[$];
    int pw_addr[$], pw_cyc[$], done_cyc[$];
    int cyc, busy_n, le;
    int v_fixed, v_full, v_l0rd, v_pm, v_ofv;
    int full_mode, ofv_mode, burst;
    bit burst_done, mid, ms_done, p_full, p_ofv;

    task automatic clear_tile();
        rd_addr.delete(); rd_cyc.delete(); wr_cyc.delete(); load_cyc.delete();
        exec_cyc.delete(); pw_addr.delete(); pw_cyc.delete(); done_cyc.delete();
        busy_n = 0; v_fixed = 0; v_full = 0; v_l0rd = 0; v_pm = 0; v_ofv = 0;
        burst = 0; burst_done = 0; ms_done = 0;
    endtask

    // Sample on the falling edge, then drive the inputs seen by the next rising edge.
    task automatic step();
        logic [33:0] w;
        @(negedge clk);
        cyc++;
        w = inst;
        if (busy) busy_n++;
        if (w[33] || !w[18] || w[5] || w[4]) v_fixed++;
        if (!w[19]) begin
            rd_addr.push_back(int'(w[17:7]));
            rd_cyc.push_back(cyc);
            if (p_full) v_full++;
        end else if (w[17:7] != 11'd0) begin
            v_fixed++;
        end
        if (w[2]) wr_cyc.push_back(cyc);
        if (w[0]) load_cyc.push_back(cyc);
        if (w[1]) exec_cyc.push_back(cyc);
        if ((w[0] || w[1]) != w[3]) v_l0rd++;
        if ((w[32] != w[31]) || (w[32] == w[6])) v_pm++;
        if (!w[32]) begin
            pw_addr.push_back(int'(w[30:20]));
            pw_cyc.push_back(cyc);
            if (!p_ofv) v_ofv++;
        end else if (w[30:20] != 11'd0) begin
            v_pm++;
        end
        if (done) done_cyc.push_back(cyc);

        start  = 1'b0;
        w_base = 11'($urandom);
        x_base = 11'($urandom);
        p_base = 11'($urandom);
        len    = 7'($urandom);
        if (mid && !ms_done && exec_cyc.size() == le) begin
            start   = 1'b1;
            ms_done = 1'b1;
        end
        case (full_mode)
            1: l0_full = ($urandom_range(0, 99) < 30);
            2: begin
                if (!burst_done && rd_cyc.size() == ROW + 1) begin
                    burst = 5;
                    burst_done = 1'b1;
                end
                l0_full = (burst > 0);
                if (burst > 0) burst--;
            end
            default: l0_full = 1'b0;
        endcase
        case (ofv_mode)
            1: ofifo_valid = $urandom_range(0, 1) == 1;
            2: ofifo_valid = !ofifo_valid;
            default: ofifo_valid = 1'b1;
        endcase
        p_full = l0_full;
        p_ofv  = ofifo_valid;
    endtask

    task automatic run_tile(input string nm, input int wb, input int xb, input int pb,
                            input int ln, input int fm, input int om, input bit md);
        bit fin;
        int nmis, nsp, ew;
        clear_tile();
        full_mode = fm; ofv_mode = om; mid = md;
        le = (ln == 0) ? 1 : ln;
        w_base = 11'(wb); x_base = 11'(xb); p_base = 11'(pb); len = 7'(ln);
        l0_full = 1'b0; ofifo_valid = (om == 0);
        p_full = l0_full; p_ofv = ofifo_valid;
        start = 1'b1;
        fin = 1'b0;
        for (int k = 0; k < 4000 && !fin; k++) begin
            step();
            if (done_cyc.size() > 0) fin = 1'b1;
        end
        chk({nm, "/finish"}, 64'(fin), 64'd1);
        for (int k = 0; k < 4; k++) step();

        chk({nm, "/rd_cnt"}, rd_cyc.size(), ROW + le);
        nmis = 0;
        for (int i = 0; i < rd_addr.size(); i++) begin
            ew = (i < ROW) ? (wb + i) % 2048 : (xb + i - ROW) % 2048;
            if (rd_addr[i] != ew) nmis++;
        end
        chk({nm, "/rd_seq"}, nmis, 0);
        chk({nm, "/wr_cnt"}, wr_cyc.size(), ROW + le);
        nmis = 0;
        for (int i = 0; i < wr_cyc.size() && i < rd_cyc.size(); i++)
            if (wr_cyc[i] != rd_cyc[i] + 1) nmis++;
        chk({nm, "/wr_follows_rd"}, nmis, 0);
        chk({nm, "/load_cnt"}, load_cyc.size(), ROW);
        chk({nm, "/exec_cnt"}, exec_cyc.size(), le);
        chk({nm, "/pw_cnt"}, pw_cyc.size(), le);
        nmis = 0;
        for (int i = 0; i < pw_addr.size(); i++)
            if (pw_addr[i] != (pb + i) % 2048) nmis++;
        chk({nm, "/pw_seq"}, nmis, 0);
        chk({nm, "/done_cnt"}, done_cyc.size(), 1);
        chk({nm, "/fixed_bits"}, v_fixed, 0);
        chk({nm, "/rd_when_full"}, v_full, 0);
        chk({nm, "/l0_rd"}, v_l0rd, 0);
        chk({nm, "/pmem_ctl"}, v_pm, 0);
        chk({nm, "/pw_no_valid"}, v_ofv, 0);
        if (fm == 2) chk({nm, "/burst_seen"}, 64'(burst_done), 64'd1);

        if (rd_cyc.size() == ROW + le && wr_cyc.size() == ROW + le && load_cyc.size() == ROW &&
            exec_cyc.size() == le && pw_cyc.size() == le && done_cyc.size() == 1) begin
            chk({nm, "/wld_then_load"}, 64'(wr_cyc[ROW-1] < load_cyc[0]), 64'd1);
            chk({nm, "/load_run"}, load_cyc[ROW-1] - load_cyc[0], ROW - 1);
            chk({nm, "/flush_gap"}, 64'(rd_cyc[ROW] - load_cyc[ROW-1] - 1 >= COL), 64'd1);
            chk({nm, "/act_then_exec"}, 64'(exec_cyc[0] > wr_cyc[ROW+le-1]), 64'd1);
            chk({nm, "/exec_run"}, exec_cyc[le-1] - exec_cyc[0], le - 1);
            chk({nm, "/exec_then_drain"}, 64'(pw_cyc[0] > exec_cyc[le-1]), 64'd1);
            chk({nm, "/done_after_drain"}, 64'(done_cyc[0] >= pw_cyc[le-1]), 64'd1);
            if (fm == 0) begin
                nsp = 0;
                for (int i = 0; i + 1 < ROW; i++)
                    if (rd_cyc[i+1] - rd_cyc[i] != 2) nsp++;
                for (int i = ROW; i + 1 < ROW + le; i++)
                    if (rd_cyc[i+1] - rd_cyc[i] != 2) nsp++;
                chk({nm, "/rd_spacing"}, nsp, 0);
            end
        end
        chk({nm, "/idle_after"}, 64'(busy), 64'd0);
`ifdef CORE_CTRL_PERF_EN
        chk({nm, "/cyc_cnt"}, 64'(cyc_cnt), 64'(busy_n));
`endif
    endtask

    task automatic reset_mid_exec();
        bit fin;
        clear_tile();
        full_mode = 0; ofv_mode = 0; mid = 1'b0; le = 10;
        w_base = 11'h020; x_base = 11'h040; p_base = 11'h060; len = 7'd10;
        l0_full = 1'b0; ofifo_valid = 1'b1; p_full = 1'b0; p_ofv = 1'b1;
        start = 1'b1;
        fin = 1'b0;
        for (int k = 0; k < 4000 && !fin; k++) begin
            step();
            if (exec_cyc.size() >= 3) fin = 1'b1;
        end
        chk("rst/reach_exec", 64'(fin), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst/inst", 64'(inst), 64'(IDLE_W));
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
`ifdef CORE_CTRL_PERF_EN
        chk("rst/cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
        step();
        chk("rst/inst_next", 64'(inst), 64'(IDLE_W));
        reset = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("rst/no_pmem_write", pw_cyc.size(), 0);
        chk("rst/stays_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; l0_full = 1'b0; ofifo_valid = 1'b0;
        w_base = '0; x_base = '0; p_base = '0; len = '0;
        p_full = 1'b0; p_ofv = 1'b0; cyc = 0;
        mid = 1'b0; full_mode = 0; ofv_mode = 0; le = 1;
        #1;
        chk("reset/inst", 64'(inst), 64'(IDLE_W));
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
`ifdef CORE_CTRL_PERF_EN
        chk("reset/cyc_cnt", 64'(cyc_cnt), 64'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_tile("wload",    'h010, 'h100, 'h200, 3, 0, 0, 1'b0);
        run_tile("l0full",   'h3F0, 'h7FC, 'h055, 8, 2, 0, 1'b0);
        run_tile("pwrap",    'h123, 'h456, 'h7FE, 4, 0, 2, 1'b0);
        run_tile("midstart", 'h0AA, 'h0BB, 'h0CC, 6, 1, 1, 1'b1);
        run_tile("len0",     'h7FF, 'h001, 'h300, 0, 0, 1, 1'b0);
        run_tile("lenmax",   'h7F9, 'h7C0, 'h7F0, 127, 0, 0, 1'b0);
        for (int t = 0; t < 15; t++) begin
            run_tile($sformatf("rnd%0d", t), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        reset_mid_exec();
        run_tile("after_rst", 'h400, 'h500, 'h600, 5, 1, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
